relogio_xadrez: RTL and testbench
=================================

Name: relogio_xadrez

Overview:
Two-player chess clock timer. Holds each player's remaining time in ticks and counts down only the active player. Supports three time-control modes: none, Fischer increment and simple delay. Sits between the tick prescaler (one-cycle `tick` pulse per time unit) and the display/game-control FSM, and raises a per-player flag when that player's time reaches zero.

Parameters:
- M, 100, initial time per player in ticks; also the saturation ceiling.
- N, 7, counter width; must satisfy M < 2^N.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- zera_s  in  1  synchronous clear/reload of both players
- inicia  in  1  start (from PARADO) or resume (from PAUSADO)
- pausa  in  1  pause the running clock
- jogada  in  1  active player completed a move; switch turn
- tick  in  1  one-cycle time-unit enable
- modo  in  2  time control: 00 none, 01 Fischer, 10 simple delay, 11 treated as 00
- tempo_inc  in  N  increment (Fischer) or delay length (simple delay), in ticks
- tempo_b  out  N  white remaining time
- tempo_p  out  N  black remaining time
- vez  out  1  active player: 0 white, 1 black
- fim_b  out  1  white flag fallen
- fim_p  out  1  black flag fallen
- estado  out  2  FSM state code

Behaviour:
- Reset (async, reset_n=0): tempo_b=tempo_p=M, vez=0, fim_b=fim_p=0, estado=PARADO, delay counter=0, registered mode=00, registered increment=0.
- States:
  - PARADO=00
  - RODANDO=01
  - PAUSADO=10
  - FIM=11
- Input priority each cycle: zera_s > pausa > inicia > jogada/tick.
- zera_s (any state): next cycle same values as reset, except estado=PARADO with time values reloaded.
- PARADO:
  - inicia -> RODANDO; on the same edge, latch modo and min(tempo_inc, M) into internal registers.
  - Delay counter loads the latched increment when mode is simple delay, else 0.
  - tick and jogada are ignored.
- RODANDO, on tick (active player A):
  - If simple-delay mode and delay counter > 0: decrement the delay counter only.
  - Otherwise decrement A's time.
  - If A's time goes 1 -> 0: set A's flag, estado -> FIM.
- RODANDO, on jogada:
  - Fischer mode: A's time = min(A + inc, M), computed in N+1 bits and then clamped.
  - vez toggles.
  - Delay counter reloads the latched increment in simple-delay mode.
- tick and jogada in the same cycle:
  - Apply the tick to A first.
  - If that tick zeroes A, the flag falls, the FSM goes to FIM, and the jogada is discarded (vez unchanged).
  - Otherwise apply the increment to the decremented value, then switch turn.
- RODANDO, on pausa: -> PAUSADO. A tick in the same cycle is dropped.
- PAUSADO:
  - All times and vez are frozen; tick and jogada are ignored.
  - inicia -> RODANDO; mode and increment are NOT re-latched.
- FIM:
  - Everything is frozen; only zera_s leaves this state.
  - Exactly one flag is set.
- Changes to modo/tempo_inc outside a PARADO->RODANDO transition have no effect.
- Latency: every output updates on the clock edge after the qualifying input. Flags are registered, not combinational.
- A time value never underflows below 0 and never exceeds M.

Decomposition:
- Package relogio_pkg:
  - State codes PARADO/RODANDO/PAUSADO/FIM.
  - Mode codes MODO_NENHUM/MODO_FISCHER/MODO_ATRASO.
- Sub-module contador_jogador #(M,N), instantiated twice (white, black).
  - Inputs: carrega (load M), decrementa, soma (add saturating with operand).
  - Outputs: valor, zero.
  - Priority: carrega > decrementa-then-soma.
- FSM, turn logic, delay counter and mode registers stay in the top module.

Test Plan:
- Reset, then inicia, then 5 ticks with modo=00 -> tempo_b=95, tempo_p=100, vez=0; jogada -> vez=1; 3 ticks -> tempo_p=97, tempo_b=95.
- Fischer, tempo_inc=10: run 20 ticks as white, then jogada -> tempo_b=90. Separately, from tempo_b=98 jogada -> tempo_b=100 (saturates at M).
- Simple delay, tempo_inc=3: 5 ticks -> tempo_b=98 (first 3 absorbed). Jogada, then 2 ticks -> tempo_p=100, delay counter=1.
- Flag: white at 1, tick asserted together with jogada -> tempo_b=0, fim_b=1, vez=0, estado=FIM. Further ticks, jogada and inicia leave all outputs unchanged. zera_s -> tempo_b=tempo_p=100, fim_b=0, estado=PARADO.
- Pause: in RODANDO, pausa and tick in the same cycle -> no decrement, estado=PAUSADO. 10 ticks plus a jogada -> no change. inicia -> RODANDO; modo changed while paused has no effect.
- Async reset: assert reset_n=0 mid-RODANDO between clock edges -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/relogio_pkg.sv
// relogio_pkg: state and time-control codes shared by the chess clock
package relogio_pkg;
    typedef enum logic [1:0] {
        PARADO  = 2'b00,
        RODANDO = 2'b01,
        PAUSADO = 2'b10,
        FIM     = 2'b11
    } estado_t;
    typedef enum logic [1:0] {
        MODO_NENHUM  = 2'b00,
        MODO_FISCHER = 2'b01,
        MODO_ATRASO  = 2'b10
    } modo_t;
endpackage

// File: rtl/relogio_xadrez_if.sv
// relogio_xadrez_if: control inputs and time/flag outputs of the chess clock
interface relogio_xadrez_if #(parameter int N = 7);
    import relogio_pkg::*;
    logic         zera_s;
    logic         inicia;
    logic         pausa;
    logic         jogada;
    logic         tick;
    logic [1:0]   modo;
    logic [N-1:0] tempo_inc;
    logic [N-1:0] tempo_b;
    logic [N-1:0] tempo_p;
    logic         vez;
    logic         fim_b;
    logic         fim_p;
    estado_t      estado;
    modport master (
        output zera_s, inicia, pausa, jogada, tick, modo, tempo_inc,
        input  tempo_b, tempo_p, vez, fim_b, fim_p, estado
    );
    modport slave (
        input  zera_s, inicia, pausa, jogada, tick, modo, tempo_inc,
        output tempo_b, tempo_p, vez, fim_b, fim_p, estado
    );
endinterface

// File: rtl/contador_jogador.sv
// contador_jogador: one player's remaining time; load M, or decrement then
// saturating add of the increment, all in one edge
module contador_jogador #(
    parameter int M = 100,
    parameter int N = 7
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         carrega,
    input  logic         decrementa,
    input  logic         soma,
    input  logic [N-1:0] operando,
    output logic [N-1:0] valor,
    output logic         zero
);
    localparam logic [N-1:0] W_M  = M[N-1:0];
    localparam logic [N:0]   W_MX = M[N:0];
    logic [N-1:0] r_valor;
    logic [N-1:0] w_dec;
    logic [N:0]   w_soma;
    always_comb begin
        w_dec  = (decrementa && r_valor != '0) ? r_valor - 1'b1 : r_valor;
        w_soma = {1'b0, w_dec} + {1'b0, operando};
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)     r_valor <= W_M;
        else if (carrega) r_valor <= W_M;
        else if (soma)    r_valor <= (w_soma > W_MX) ? W_M : w_soma[N-1:0];
        else              r_valor <= w_dec;
    assign valor = r_valor;
    assign zero  = r_valor == '0;
endmodule

// File: rtl/relogio_xadrez.sv
// relogio_xadrez: two-player chess clock with none/Fischer/simple-delay
// time control, per-player flags and a PARADO/RODANDO/PAUSADO/FIM FSM
module relogio_xadrez
    import relogio_pkg::*;
#(
    parameter int M = 100,
    parameter int N = 7
) (
    input logic              clock,
    input logic              reset_n,
    relogio_xadrez_if.slave  bus
);
    localparam logic [N-1:0] W_M  = M[N-1:0];
    localparam logic [N-1:0] W_UM = {{(N-1){1'b0}}, 1'b1};
    estado_t      r_estado;
    modo_t        r_modo;
    logic [N-1:0] r_inc;
    logic [N-1:0] r_atraso;
    logic         r_vez;
    logic         r_fim_b;
    logic         r_fim_p;
    logic [N-1:0] w_valor_b, w_valor_p, w_ativo, w_inc_lim;
    logic         w_zero_b, w_zero_p;
    logic         w_inicio, w_run, w_tick, w_absorve, w_dec, w_cai, w_jog, w_soma;
    always_comb begin
        w_inicio  = r_estado == PARADO && !bus.zera_s && !bus.pausa && bus.inicia;
        w_inc_lim = (bus.tempo_inc > W_M) ? W_M : bus.tempo_inc;
        w_run     = r_estado == RODANDO && !bus.zera_s && !bus.pausa && !bus.inicia;
        w_tick    = w_run && bus.tick;
        w_absorve = w_tick && r_modo == MODO_ATRASO && r_atraso != '0;
        w_ativo   = r_vez ? w_valor_p : w_valor_b;
        w_dec     = w_tick && !w_absorve && !(r_vez ? w_zero_p : w_zero_b);
        // a tick that empties the clock wins over a move in the same cycle
        w_cai     = w_dec && w_ativo == W_UM;
        w_jog     = w_run && bus.jogada && !w_cai;
        w_soma    = w_jog && r_modo == MODO_FISCHER;
    end
    contador_jogador #(.M(M), .N(N)) u_branco (
        .clock(clock), .reset_n(reset_n), .carrega(bus.zera_s),
        .decrementa(w_dec && !r_vez), .soma(w_soma && !r_vez), .operando(r_inc),
        .valor(w_valor_b), .zero(w_zero_b)
    );
    contador_jogador #(.M(M), .N(N)) u_preto (
        .clock(clock), .reset_n(reset_n), .carrega(bus.zera_s),
        .decrementa(w_dec && r_vez), .soma(w_soma && r_vez), .operando(r_inc),
        .valor(w_valor_p), .zero(w_zero_p)
    );
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n || bus.zera_s) begin
            r_estado <= PARADO;
            r_vez    <= 1'b0;
            r_fim_b  <= 1'b0;
            r_fim_p  <= 1'b0;
            r_atraso <= '0;
            r_modo   <= MODO_NENHUM;
            r_inc    <= '0;
        end else if (w_inicio) begin
            r_estado <= RODANDO;
            r_modo   <= (bus.modo == MODO_FISCHER || bus.modo == MODO_ATRASO) ? modo_t'(bus.modo) : MODO_NENHUM;
            r_inc    <= w_inc_lim;
            r_atraso <= (bus.modo == MODO_ATRASO) ? w_inc_lim : '0;
        end else if (r_estado == RODANDO && bus.pausa) begin
            r_estado <= PAUSADO;
        end else if (r_estado == PAUSADO && !bus.pausa && bus.inicia) begin
            r_estado <= RODANDO;
        end else if (w_cai) begin
            r_estado <= FIM;
            r_fim_b  <= ~r_vez;
            r_fim_p  <= r_vez;
        end else if (w_jog) begin
            r_vez    <= ~r_vez;
            r_atraso <= (r_modo == MODO_ATRASO) ? r_inc : '0;
        end else if (w_absorve) begin
            r_atraso <= r_atraso - 1'b1;
        end
    assign bus.tempo_b = w_valor_b;
    assign bus.tempo_p = w_valor_p;
    assign bus.vez     = r_vez;
    assign bus.fim_b   = r_fim_b;
    assign bus.fim_p   = r_fim_p;
    assign bus.estado  = r_estado;
endmodule

// File: tb/tb_relogio_xadrez.sv
// tb_relogio_xadrez: directed test-plan scenarios plus random stimulus,
// checked every cycle against a behavioural chess-clock model
module tb_relogio_xadrez;
    localparam int M = 100;
    localparam int N = 7;
    logic clock = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_err = 0;
    bit   en = 1'b0;
    int   m_t[2];
    int   m_fim[2];
    int   m_vez, m_st, m_dly, m_mode, m_inc;

    relogio_xadrez_if #(.N(N)) bus();
    relogio_xadrez #(.M(M), .N(N)) dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t[0] = M; m_t[1] = M; m_fim[0] = 0; m_fim[1] = 0;
        m_vez = 0; m_st = 0; m_dly = 0; m_mode = 0; m_inc = 0;
    endtask

    // expected state after the coming clock edge, from the current inputs
    task automatic model_step();
        int a;
        bit caiu;
        a = m_vez;
        caiu = 1'b0;
        if (bus.zera_s) model_reset();
        else if (m_st == 0) begin
            if (!bus.pausa && bus.inicia) begin
                m_st = 1;
                m_mode = (bus.modo == 2'd3) ? 0 : int'(bus.modo);
                m_inc = (int'(bus.tempo_inc) > M) ? M : int'(bus.tempo_inc);
                m_dly = (m_mode == 2) ? m_inc : 0;
            end
        end else if (m_st == 1) begin
            if (bus.pausa) m_st = 2;
            else if (!bus.inicia) begin
                if (bus.tick) begin
                    if (m_mode == 2 && m_dly > 0) m_dly--;
                    else begin
                        m_t[a]--;
                        if (m_t[a] == 0) begin
                            m_fim[a] = 1; m_st = 3; caiu = 1'b1;
                        end
                    end
                end
                if (bus.jogada && !caiu) begin
                    if (m_mode == 1) m_t[a] = (m_t[a] + m_inc > M) ? M : m_t[a] + m_inc;
                    if (m_mode == 2) m_dly = m_inc;
                    m_vez = 1 - m_vez;
                end
            end
        end else if (m_st == 2) begin
            if (!bus.pausa && bus.inicia) m_st = 1;
        end
    endtask

    always @(negedge clock)
        if (en) begin
            chk("tempo_b", 32'(bus.tempo_b), m_t[0]);
            chk("tempo_p", 32'(bus.tempo_p), m_t[1]);
            chk("vez", 32'(bus.vez), m_vez);
            chk("fim_b", 32'(bus.fim_b), m_fim[0]);
            chk("fim_p", 32'(bus.fim_p), m_fim[1]);
            chk("estado", 32'(bus.estado), m_st);
        end

    task automatic drive(input bit z, input bit i, input bit p, input bit j, input bit t);
        @(negedge clock);
        #1;
        bus.zera_s = z; bus.inicia = i; bus.pausa = p; bus.jogada = j; bus.tick = t;
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.zera_s = 0; bus.inicia = 0; bus.pausa = 0; bus.jogada = 0; bus.tick = 0;
        bus.modo = 2'd0; bus.tempo_inc = '0;
        model_reset();
        #12;
        chk("reset tempo_b", 32'(bus.tempo_b), 100);
        chk("reset tempo_p", 32'(bus.tempo_p), 100);
        chk("reset vez", 32'(bus.vez), 0);
        chk("reset fim", 32'({bus.fim_b, bus.fim_p}), 0);
        chk("reset estado", 32'(bus.estado), 0);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        en = 1'b1;
        // no time control
        drive(0, 1, 0, 0, 0);
        ticks(5);
        chk("nenhum tempo_b", 32'(bus.tempo_b), 95);
        chk("nenhum tempo_p", 32'(bus.tempo_p), 100);
        chk("nenhum vez", 32'(bus.vez), 0);
        drive(0, 0, 0, 1, 0);
        chk("nenhum troca", 32'(bus.vez), 1);
        ticks(3);
        chk("nenhum tempo_p2", 32'(bus.tempo_p), 97);
        chk("nenhum tempo_b2", 32'(bus.tempo_b), 95);
        // Fischer increment
        bus.modo = 2'd1; bus.tempo_inc = 7'd10;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        ticks(20);
        drive(0, 0, 0, 1, 0);
        chk("fischer inc", 32'(bus.tempo_b), 90);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        ticks(2);
        drive(0, 0, 0, 1, 0);
        chk("fischer satura", 32'(bus.tempo_b), 100);
        // simple delay
        bus.modo = 2'd2; bus.tempo_inc = 7'd3;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        ticks(5);
        chk("atraso tempo_b", 32'(bus.tempo_b), 98);
        drive(0, 0, 0, 1, 0);
        ticks(2);
        chk("atraso tempo_p", 32'(bus.tempo_p), 100);
        ticks(1);
        chk("atraso ultimo", 32'(bus.tempo_p), 100);
        ticks(1);
        chk("atraso fim", 32'(bus.tempo_p), 99);
        // flag with simultaneous tick and move
        bus.modo = 2'd0; bus.tempo_inc = 7'd0;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        ticks(99);
        chk("flag antes", 32'(bus.tempo_b), 1);
        drive(0, 0, 0, 1, 1);
        chk("flag tempo_b", 32'(bus.tempo_b), 0);
        chk("flag fim_b", 32'(bus.fim_b), 1);
        chk("flag vez", 32'(bus.vez), 0);
        chk("flag estado", 32'(bus.estado), 3);
        ticks(3);
        drive(0, 0, 0, 1, 1);
        drive(0, 1, 0, 0, 0);
        chk("fim congelado", 32'({bus.tempo_b, bus.tempo_p, bus.vez, bus.fim_b, bus.fim_p, bus.estado}),
            32'({7'd0, 7'd100, 1'b0, 1'b1, 1'b0, 2'd3}));
        drive(1, 0, 0, 0, 0);
        chk("zera tempos", 32'({bus.tempo_b, bus.tempo_p}), 32'({7'd100, 7'd100}));
        chk("zera fim_b", 32'(bus.fim_b), 0);
        chk("zera estado", 32'(bus.estado), 0);
        // pause
        drive(0, 1, 0, 0, 0);
        ticks(2);
        drive(0, 0, 1, 0, 1);
        chk("pausa tempo_b", 32'(bus.tempo_b), 98);
        chk("pausa estado", 32'(bus.estado), 2);
        ticks(10);
        drive(0, 0, 0, 1, 0);
        chk("pausa congelada", 32'({bus.tempo_b, bus.vez}), 32'({7'd98, 1'b0}));
        bus.modo = 2'd1; bus.tempo_inc = 7'd50;
        drive(0, 1, 0, 0, 0);
        chk("retoma estado", 32'(bus.estado), 1);
        drive(0, 0, 0, 1, 0);
        chk("retoma sem inc", 32'({bus.tempo_b, bus.vez}), 32'({7'd98, 1'b1}));
        // asynchronous reset between edges
        ticks(4);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async tempo_p", 32'(bus.tempo_p), 100);
        chk("async vez", 32'(bus.vez), 0);
        chk("async estado", 32'(bus.estado), 0);
        bus.zera_s = 0; bus.inicia = 0; bus.pausa = 0; bus.jogada = 0; bus.tick = 0;
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        // random play
        for (int k = 0; k < 4000; k++) begin
            bus.modo = 2'($urandom_range(0, 3));
            bus.tempo_inc = 7'($urandom_range(0, 127));
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1);
        end
        @(negedge clock);
        #1;
        en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
